operand_read: RTL

- Register-read (issue) stage between ID and EX, on the reading side of the three-group (R/F/M) general register file.
- Drives the register file's rs1/rs2/rs3 group/index read ports and latches the returned operands into a pipeline register for EX.
- Holds a scoreboard of pending writebacks. An instruction stalls until every source and its destination are free, so no RAW or WAW hazard can reach EX.
- Busy bits are cleared by the writeback stage's write-enable, group and index.

---
 rtl/operand_read_pkg.sv | 21 ++
 rtl/operand_read_scoreboard.sv | 47 ++++
 rtl/operand_read.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/operand_read_pkg.sv
// Shared definitions for the operand-read (issue) stage: register group
// encoding, default widths and the busy-tracking predicate.
package operand_read_pkg;

  localparam int GPR_NREG = 32;
  localparam int GPR_XLEN = 32;
  localparam int GPR_MLEN = 512;

  localparam logic [1:0] REG_GROUP_R       = 2'd0;
  localparam logic [1:0] REG_GROUP_F       = 2'd1;
  localparam logic [1:0] REG_GROUP_M       = 2'd2;
  localparam logic [1:0] REG_GROUP_INVALID = 2'd3;

  localparam logic [4:0] zero5 = 5'd0;

  // x0 is hard-wired zero and INVALID means "no register", so neither is tracked.
  function automatic logic is_tracked(input logic [1:0] group, input logic [4:0] index);
    return (group != REG_GROUP_INVALID) && !((group == REG_GROUP_R) && (index == zero5));
  endfunction

endpackage

// File: rtl/operand_read_scoreboard.sv
// Pending-writeback busy bits for the R/F/M groups, with one set port, one
// clear port, three source lookups and one destination lookup.
module operand_read_scoreboard
  import operand_read_pkg::*;
#(
  parameter int NREG = GPR_NREG
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [1:0] set_group,
  input  logic [4:0] set_index,
  input  logic       clr_en,
  input  logic [1:0] clr_group,
  input  logic [4:0] clr_index,
  input  logic [1:0] lk1_group,
  input  logic [4:0] lk1_index,
  input  logic [1:0] lk2_group,
  input  logic [4:0] lk2_index,
  input  logic [1:0] lk3_group,
  input  logic [4:0] lk3_index,
  input  logic [1:0] lkd_group,
  input  logic [4:0] lkd_index,
  output logic [2:0] src_busy,
  output logic       dst_busy
);

  logic [NREG-1:0] busy [3];

  // The set is written last so a new outstanding write beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < 3; g++) busy[g] <= '0;
    end else begin
      if (clr_en && is_tracked(clr_group, clr_index)) busy[clr_group][clr_index] <= 1'b0;
      if (set_en && is_tracked(set_group, set_index)) busy[set_group][set_index] <= 1'b1;
    end
  end

  always_comb begin
    src_busy[0] = is_tracked(lk1_group, lk1_index) ? busy[lk1_group][lk1_index] : 1'b0;
    src_busy[1] = is_tracked(lk2_group, lk2_index) ? busy[lk2_group][lk2_index] : 1'b0;
    src_busy[2] = is_tracked(lk3_group, lk3_index) ? busy[lk3_group][lk3_index] : 1'b0;
    dst_busy    = is_tracked(lkd_group, lkd_index) ? busy[lkd_group][lkd_index] : 1'b0;
  end

endmodule

// File: rtl/operand_read.sv
// Register-read stage between ID and EX with RAW/WAW interlock.
// Optional writeback forwarding is enabled with `define OPREAD_WB_BYPASS_EN.
module operand_read
  import operand_read_pkg::*;
#(
  parameter int NREG = GPR_NREG,
  parameter int XLEN = GPR_XLEN,
  parameter int MLEN = GPR_MLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ID_valid,
  output logic            ready,
  input  logic [31:0]     id_pc,
  input  logic [31:0]     id_inst,
  input  logic [1:0]      id_rs1_group,
  input  logic [4:0]      id_rs1_index,
  input  logic [1:0]      id_rs2_group,
  input  logic [4:0]      id_rs2_index,
  input  logic [1:0]      id_rs3_group,
  input  logic [4:0]      id_rs3_index,
  input  logic [1:0]      id_rd_group,
  input  logic [4:0]      id_rd_index,
  output logic [1:0]      gpr_rs1_group,
  output logic [4:0]      gpr_rs1_index,
  output logic [1:0]      gpr_rs2_group,
  output logic [4:0]      gpr_rs2_index,
  output logic [1:0]      gpr_rs3_group,
  output logic [4:0]      gpr_rs3_index,
  input  logic [XLEN-1:0] gpr_dout_R_rs1,
  input  logic [XLEN-1:0] gpr_dout_R_rs2,
  input  logic [XLEN-1:0] gpr_dout_R_rs3,
  input  logic [XLEN-1:0] gpr_dout_F_rs1,
  input  logic [XLEN-1:0] gpr_dout_F_rs2,
  input  logic [XLEN-1:0] gpr_dout_F_rs3,
  input  logic [MLEN-1:0] gpr_dout_M_rs1,
  input  logic [MLEN-1:0] gpr_dout_M_rs2,
  input  logic [MLEN-1:0] gpr_dout_M_rs3,
  input  logic            wb_we,
  input  logic [1:0]      wb_rd_group,
  input  logic [4:0]      wb_rd_index,
  input  logic [XLEN-1:0] wb_din_R,
  input  logic [XLEN-1:0] wb_din_F,
  input  logic [MLEN-1:0] wb_din_M,
  output logic            valid,
  input  logic            EX_ready,
  output logic [31:0]     pc,
  output logic [31:0]     inst,
  output logic [1:0]      rd_group,
  output logic [4:0]      rd_index,
  output logic [XLEN-1:0] src1_R,
  output logic [XLEN-1:0] src2_R,
  output logic [XLEN-1:0] src3_R,
  output logic [XLEN-1:0] src1_F,
  output logic [XLEN-1:0] src2_F,
  output logic [XLEN-1:0] src3_F,
  output logic [MLEN-1:0] src1_M,
  output logic [MLEN-1:0] src2_M,
  output logic [MLEN-1:0] src3_M
);

  logic [1:0]      rs_group [3];
  logic [4:0]      rs_index [3];
  logic [XLEN-1:0] dout_R [3];
  logic [XLEN-1:0] dout_F [3];
  logic [MLEN-1:0] dout_M [3];
  logic [XLEN-1:0] opnd_R [3];
  logic [XLEN-1:0] opnd_F [3];
  logic [MLEN-1:0] opnd_M [3];
  logic [XLEN-1:0] src_R_q [3];
  logic [XLEN-1:0] src_F_q [3];
  logic [MLEN-1:0] src_M_q [3];
  logic [2:0]      src_busy, src_blocked, wb_hit;
  logic            dst_busy, issue;

  assign rs_group = '{id_rs1_group, id_rs2_group, id_rs3_group};
  assign rs_index = '{id_rs1_index, id_rs2_index, id_rs3_index};
  assign dout_R   = '{gpr_dout_R_rs1, gpr_dout_R_rs2, gpr_dout_R_rs3};
  assign dout_F   = '{gpr_dout_F_rs1, gpr_dout_F_rs2, gpr_dout_F_rs3};
  assign dout_M   = '{gpr_dout_M_rs1, gpr_dout_M_rs2, gpr_dout_M_rs3};

  assign gpr_rs1_group = id_rs1_group;
  assign gpr_rs1_index = id_rs1_index;
  assign gpr_rs2_group = id_rs2_group;
  assign gpr_rs2_index = id_rs2_index;
  assign gpr_rs3_group = id_rs3_group;
  assign gpr_rs3_index = id_rs3_index;

  operand_read_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue),
    .set_group (id_rd_group),
    .set_index (id_rd_index),
    .clr_en    (wb_we),
    .clr_group (wb_rd_group),
    .clr_index (wb_rd_index),
    .lk1_group (id_rs1_group),
    .lk1_index (id_rs1_index),
    .lk2_group (id_rs2_group),
    .lk2_index (id_rs2_index),
    .lk3_group (id_rs3_group),
    .lk3_index (id_rs3_index),
    .lkd_group (id_rd_group),
    .lkd_index (id_rd_index),
    .src_busy  (src_busy),
    .dst_busy  (dst_busy)
  );

  always_comb begin
    for (int k = 0; k < 3; k++) begin
`ifdef OPREAD_WB_BYPASS_EN
      wb_hit[k] = wb_we && is_tracked(rs_group[k], rs_index[k]) &&
                  (wb_rd_group == rs_group[k]) && (wb_rd_index == rs_index[k]);
`else
      wb_hit[k] = 1'b0;
`endif
      src_blocked[k] = src_busy[k] && !wb_hit[k];
      opnd_R[k] = dout_R[k];
      opnd_F[k] = dout_F[k];
      opnd_M[k] = dout_M[k];
`ifdef OPREAD_WB_BYPASS_EN
      if (wb_hit[k]) begin
        case (rs_group[k])
          REG_GROUP_R: opnd_R[k] = wb_din_R;
          REG_GROUP_F: opnd_F[k] = wb_din_F;
          REG_GROUP_M: opnd_M[k] = wb_din_M;
          default: ;
        endcase
      end
`endif
    end
  end

`ifndef OPREAD_WB_BYPASS_EN
  logic unused_wb_din;
  assign unused_wb_din = ^{wb_din_R, wb_din_F, wb_din_M};
`endif

  // Handshake: ID transfers when ID_valid && ready; EX transfers when valid && EX_ready.
  // The register may refill in the same cycle EX drains it.
  assign issue = ID_valid && (src_blocked == 3'b000) && !dst_busy && (!valid || EX_ready);
  assign ready = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      pc       <= '0;
      inst     <= '0;
      rd_group <= REG_GROUP_INVALID;
      rd_index <= zero5;
      for (int k = 0; k < 3; k++) begin
        src_R_q[k] <= '0;
        src_F_q[k] <= '0;
        src_M_q[k] <= '0;
      end
    end else if (issue) begin
      valid    <= 1'b1;
      pc       <= id_pc;
      inst     <= id_inst;
      rd_group <= id_rd_group;
      rd_index <= id_rd_index;
      for (int k = 0; k < 3; k++) begin
        src_R_q[k] <= opnd_R[k];
        src_F_q[k] <= opnd_F[k];
        src_M_q[k] <= opnd_M[k];
      end
    end else if (EX_ready && valid) begin
      valid <= 1'b0;
    end
  end

  assign src1_R = src_R_q[0];
  assign src2_R = src_R_q[1];
  assign src3_R = src_R_q[2];
  assign src1_F = src_F_q[0];
  assign src2_F = src_F_q[1];
  assign src3_F = src_F_q[2];
  assign src1_M = src_M_q[0];
  assign src2_M = src_M_q[1];
  assign src3_M = src_M_q[2];

endmodule
